fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 10, width of each FIFO data word.
REQ-002 SHALL have parameter NUM_FIFOS, fixed at 4, number of upstream FIFOs served.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset_L  input  1  synchronous, active-low reset.
REQ-005 SHALL have port fifo_empty  input  4  empty_flag of FIFO i on bit i.
REQ-006 SHALL have port fifo_data  input  4*WORD_SIZE  data_out of FIFO i on bits [i*WORD_SIZE +: WORD_SIZE].
REQ-007 SHALL have port down_almost_full  input  1  backpressure from the downstream FIFO's almost_full_flag.
REQ-008 SHALL have port fifo_rd_en  output  4  one-hot pop strobe; bit i drives rd_en of FIFO i.
REQ-009 SHALL have port data_out  output  WORD_SIZE  popped word.
REQ-010 SHALL have port valid_out  output  1  data_out/src_out valid this cycle.
REQ-011 SHALL have port src_out  output  2  index of the FIFO that supplied data_out.
REQ-012 SHALL have port pop_count  output  8  total pops since reset, wraps 255->0.

Function
REQ-013 SHALL implement FSM states IDLE, POP, HOLD; all outputs registered.
REQ-014 Eligibility: FIFO i eligible when fifo_empty[i]=0, down_almost_full=0, and i is not the FIFO popped in the immediately preceding POP cycle.
REQ-015 IDLE: if any FIFO eligible, grant per selection policy (REQ-027/028), go to POP; else stay IDLE.
REQ-016 POP: fifo_rd_en asserts only the granted bit for exactly one cycle; pop_count increments by 1; next state HOLD.
REQ-017 HOLD: capture fifo_data slice of the granted FIFO into data_out and the grant index into src_out; valid_out=1 in the following cycle for exactly one cycle.
REQ-018 HOLD: if another FIFO is eligible (REQ-014), grant it and go directly to POP; else go to IDLE.
REQ-019 Pop-to-data latency SHALL be 2 cycles: rd_en high in cycle P, valid_out high in cycle P+2.
REQ-020 The same FIFO SHALL never be popped in two POP cycles less than 3 cycles apart (covers 2-cycle empty_flag lag).
REQ-021 fifo_rd_en SHALL be all-zero outside POP; at most one bit set at any time.
REQ-022 down_almost_full is sampled only at grant decisions; a pop already in POP/HOLD completes regardless.
REQ-023 Peak throughput SHALL be one word per 2 cycles when alternating FIFOs; one per 3 cycles with a single non-empty FIFO.
REQ-024 pop_count SHALL be 8-bit modulo: after 255 the next pop yields 0.

Reset
REQ-025 While reset_L=0 at posedge: state IDLE, fifo_rd_en=0, data_out=0, valid_out=0, src_out=0, pop_count=0, last grant=3 (next round-robin candidate FIFO0).
REQ-026 Reset asserted in POP or HOLD SHALL abort: no valid_out for the in-flight pop, rd_en low from the next edge.

Configuration
REQ-027 With macro ARB_FIXED_PRIORITY_EN defined: selection SHALL be fixed priority, FIFO0 highest, FIFO3 lowest, among eligible FIFOs.
REQ-028 Without ARB_FIXED_PRIORITY_EN: selection SHALL be round-robin, searching from (last grant+1) mod 4 upward with wrap.

Verification
REQ-029 Reset, all fifo_empty=4'b1111 for 10 cycles -> fifo_rd_en=0, valid_out=0, pop_count=0 throughout.
REQ-030 Only FIFO2 non-empty, data 10'h2A5 -> rd_en=4'b0100 in cycle P, valid_out=1, data_out=10'h2A5, src_out=2 in cycle P+2; next FIFO2 pop no earlier than P+3.
REQ-031 Round-robin build, all four non-empty continuously -> grant order 0,1,2,3,0, POP every 2 cycles, src_out sequence 0,1,2,3,0.
REQ-032 ARB_FIXED_PRIORITY_EN build, FIFO0 and FIFO3 non-empty -> grants alternate 0,3,0,3 (REQ-014 exclusion), FIFO3 never starved.
REQ-033 down_almost_full=1 with FIFO1 non-empty -> no pop; deassert -> pop of FIFO1 on the next IDLE grant; assert during POP -> that word still delivered.
REQ-034 257 pops -> pop_count=1; reset_L=0 during HOLD -> valid_out stays 0 next cycle, all outputs at REQ-025 values.

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter draining four upstream FIFOs into one downstream FIFO, one pop at a time.
// Default selection is round-robin; define ARB_FIXED_PRIORITY_EN for fixed priority (FIFO0 first).
module fifo_rd_arbiter #(
    parameter int unsigned WORD_SIZE = 10,
    parameter int unsigned NUM_FIFOS = 4
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS*WORD_SIZE-1:0] fifo_data,
    input  logic                           down_almost_full,
    output logic [NUM_FIFOS-1:0]           fifo_rd_en,
    output logic [WORD_SIZE-1:0]           data_out,
    output logic                           valid_out,
    output logic [1:0]                     src_out,
    output logic [7:0]                     pop_count
);

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic [NUM_FIFOS-1:0]   rd_en_q, rd_en_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic [1:0]             src_q, src_d;
    logic [7:0]             count_q, count_d;

    logic [NUM_FIFOS-1:0]   excl;
    logic [NUM_FIFOS-1:0]   elig;
    logic                   pick_valid;
    logic [1:0]             pick_idx;

    // Only the FIFO popped in the cycle just before HOLD is excluded; its empty flag lags.
    always_comb begin
        excl = '0;
        if (state_q == StHold) begin
            excl[grant_q] = 1'b1;
        end
        elig = ~fifo_empty & ~excl & {NUM_FIFOS{~down_almost_full}};
    end

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        pick_valid = |elig;
        pick_idx   = '0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_idx = 2'(i);
            end
        end
    end
`else
    // Walk candidates farthest-first so the nearest one after the last grant wins.
    always_comb begin
        pick_valid = |elig;
        pick_idx   = '0;
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            if (elig[grant_q + 2'(k + 1)]) begin
                pick_idx = grant_q + 2'(k + 1);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rd_en_d = '0;
        data_d  = data_q;
        valid_d = 1'b0;
        src_d   = src_q;
        count_d = count_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StPop;
                    grant_d = pick_idx;
                    rd_en_d = {{(NUM_FIFOS-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            StPop: begin
                state_d = StHold;
                count_d = count_q + 8'd1;
            end
            StHold: begin
                data_d  = fifo_data[int'(grant_q) * WORD_SIZE +: WORD_SIZE];
                src_d   = grant_q;
                valid_d = 1'b1;
                if (pick_valid) begin
                    state_d = StPop;
                    grant_d = pick_idx;
                    rd_en_d = {{(NUM_FIFOS-1){1'b0}}, 1'b1} << pick_idx;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= StIdle;
            grant_q <= 2'd3;
            rd_en_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rd_en_q <= rd_en_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            count_q <= count_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign src_out    = src_q;
    assign pop_count  = count_q;

    a_rd_en_onehot0: assert property (@(posedge clk) $onehot0(rd_en_q));
    a_rd_en_in_pop:  assert property (@(posedge clk) (rd_en_q != '0) == (state_q == StPop));

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: behavioural FIFO models feed the arbiter, a scoreboard checks output.
module tb_fifo_rd_arbiter;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset_L;
    logic [3:0]     fifo_empty;
    logic [4*W-1:0] fifo_data;
    logic           down_almost_full;
    logic [3:0]     fifo_rd_en;
    logic [W-1:0]   data_out;
    logic           valid_out;
    logic [1:0]     src_out;
    logic [7:0]     pop_count;

    fifo_rd_arbiter #(.WORD_SIZE(W), .NUM_FIFOS(4)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
        .down_almost_full (down_almost_full),
        .fifo_rd_en       (fifo_rd_en),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .src_out          (src_out),
        .pop_count        (pop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { int cyc; logic [1:0] idx; } pop_t;
    typedef struct packed { int cyc; logic [1:0] src; logic [W-1:0] data; } out_t;
    typedef struct packed { logic [1:0] src; logic [W-1:0] data; } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int multi_hot = 0;
    int underflow = 0;

    logic [W-1:0] mem [4][$];
    logic [W-1:0] fifo_word [4];
    logic [3:0]   rd_en_s = '0;
    pop_t pop_q[$];
    out_t obs_q[$];
    exp_t exp_q[$];

    assign fifo_data = {fifo_word[3], fifo_word[2], fifo_word[1], fifo_word[0]};

    // FIFO models: registered read data, empty flag reflects occupancy after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rd_en_s[i]) begin
                if (mem[i].size() > 0) fifo_word[i] <= mem[i].pop_front();
                else underflow <= underflow + 1;
            end
            fifo_empty[i] <= (mem[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        rd_en_s <= fifo_rd_en;
        if ($countones(fifo_rd_en) > 1) multi_hot <= multi_hot + 1;
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en[i]) pop_q.push_back(pop_t'{cyc, 2'(i)});
        end
        if (valid_out) obs_q.push_back(out_t'{cyc, src_out, data_out});
    end

    task automatic load(input int f, input logic [W-1:0] w);
        mem[f].push_back(w);
        exp_q.push_back(exp_t'{2'(f), w});
    endtask

    task automatic clear_sb();
        pop_q.delete();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic wait_outs(input int n, input int budget, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        checks++;
        if (fifo_rd_en !== 4'b0 || valid_out !== 1'b0 || data_out !== '0 ||
            src_out !== 2'd0 || pop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values rd_en=%b valid=%b data=%h src=%0d cnt=%0d want all 0",
                     fifo_rd_en, valid_out, data_out, src_out, pop_count);
        end
        reset_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en !== 4'b0 || valid_out !== 1'b0 || pop_count !== 8'd0) begin
                errors++;
                $display("FAIL all_empty_idle cyc=%0d rd_en=%b valid=%b cnt=%0d want 0/0/0",
                         i, fifo_rd_en, valid_out, pop_count);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        pop_t p0, p1;
        clear_sb();
        load(2, 10'h2A5);
        load(2, 10'h155);
        wait_outs(2, 40, ok);
        checks++;
        if (!ok || pop_q.size() != 2) begin
            errors++;
            $display("FAIL single_count outs=%0d pops=%0d want 2/2", obs_q.size(), pop_q.size());
            return;
        end
        p0 = pop_q[0];
        p1 = pop_q[1];
        checks++;
        if (p0.idx !== 2'd2 || p1.idx !== 2'd2) begin
            errors++;
            $display("FAIL single_idx got %0d,%0d want 2,2", p0.idx, p1.idx);
        end
        checks++;
        if (p1.cyc - p0.cyc != 3) begin
            errors++;
            $display("FAIL single_respacing got %0d want 3", p1.cyc - p0.cyc);
        end
        for (int i = 0; i < 2; i++) begin
            exp_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            pop_t p = pop_q.pop_front();
            checks++;
            if (o.src !== e.src || o.data !== e.data || o.cyc - p.cyc != 2) begin
                errors++;
                $display("FAIL single_word%0d got src=%0d data=%h lat=%0d want src=%0d data=%h lat=2",
                         i, o.src, o.data, o.cyc - p.cyc, e.src, e.data);
            end
        end
    endtask

    // Expected grant order is a fixed table per build; every gap between pops must be 2 cycles.
    task automatic test_order(input string name, input int n, input int order[]);
        bit ok;
        int k[4] = '{0, 0, 0, 0};
        do_reset();
        clear_sb();
        for (int i = 0; i < n; i++) begin
            int f = order[i];
            mem[f].push_back(10'(f * 64 + k[f] + 16));
            exp_q.push_back(exp_t'{2'(f), 10'(f * 64 + k[f] + 16)});
            k[f]++;
        end
        wait_outs(n, 20 * n, ok);
        checks++;
        if (!ok || pop_q.size() != n) begin
            errors++;
            $display("FAIL %s_count outs=%0d pops=%0d want %0d", name, obs_q.size(), pop_q.size(), n);
            return;
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (pop_q[i].cyc - pop_q[i-1].cyc != 2) begin
                errors++;
                $display("FAIL %s_spacing pop%0d gap=%0d want 2", name, i, pop_q[i].cyc - pop_q[i-1].cyc);
            end
        end
        for (int i = 0; i < n; i++) begin
            exp_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            pop_t p = pop_q.pop_front();
            checks++;
            if (p.idx !== e.src || o.src !== e.src || o.data !== e.data || o.cyc - p.cyc != 2) begin
                errors++;
                $display("FAIL %s_word%0d got pop=%0d src=%0d data=%h lat=%0d want %0d/%0d/%h/2",
                         name, i, p.idx, o.src, o.data, o.cyc - p.cyc, e.src, e.src, e.data);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int c_rel;
        int t;
        clear_sb();
        down_almost_full = 1'b1;
        load(1, 10'h3C3);
        repeat (8) @(negedge clk);
        checks++;
        if (pop_q.size() != 0) begin
            errors++;
            $display("FAIL bp_blocked pops=%0d want 0", pop_q.size());
        end
        down_almost_full = 1'b0;
        c_rel = cyc;
        wait_outs(1, 20, ok);
        checks++;
        if (!ok || pop_q.size() != 1) begin
            errors++;
            $display("FAIL bp_release outs=%0d pops=%0d want 1/1", obs_q.size(), pop_q.size());
        end else begin
            exp_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            pop_t p = pop_q.pop_front();
            checks++;
            if (p.idx !== 2'd1 || p.cyc != c_rel + 1 || o.data !== e.data || o.src !== e.src) begin
                errors++;
                $display("FAIL bp_release_word got pop=%0d@%0d data=%h src=%0d want 1@%0d data=%h src=1",
                         p.idx, p.cyc, o.data, o.src, c_rel + 1, e.data);
            end
        end
        clear_sb();
        load(1, 10'h0F0);
        t = 0;
        while (fifo_rd_en == 4'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        down_almost_full = 1'b1;
        wait_outs(1, 10, ok);
        checks++;
        if (!ok || obs_q.size() != 1) begin
            errors++;
            $display("FAIL bp_inflight outs=%0d want 1", obs_q.size());
        end else begin
            exp_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o.data !== e.data || o.src !== e.src) begin
                errors++;
                $display("FAIL bp_inflight_word got %h/%0d want %h/%0d", o.data, o.src, e.data, e.src);
            end
        end
        down_almost_full = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        int n = 257;
        do_reset();
        clear_sb();
        for (int i = 0; i < n; i++) load(i % 2, 10'((i * 37 + 5) % 1024));
        wait_outs(n, 1500, ok);
        checks++;
        if (!ok || obs_q.size() != n) begin
            errors++;
            $display("FAIL wrap_count outs=%0d want %0d", obs_q.size(), n);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o.src !== e.src || o.data !== e.data) begin
                errors++;
                $display("FAIL wrap_word got %0d/%h want %0d/%h", o.src, o.data, e.src, e.data);
            end
        end
        checks++;
        if (pop_count !== 8'd1) begin
            errors++;
            $display("FAIL wrap_pop_count got %0d want 1", pop_count);
        end
    endtask

    task automatic test_abort();
        int t = 0;
        do_reset();
        clear_sb();
        mem[2].push_back(10'h2AA);
        while (fifo_rd_en == 4'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (fifo_rd_en !== 4'b0100) begin
            errors++;
            $display("FAIL abort_pop got rd_en=%b want 0100", fifo_rd_en);
        end
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || fifo_rd_en !== 4'b0 || data_out !== '0 ||
            src_out !== 2'd0 || pop_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_outputs valid=%b rd_en=%b data=%h src=%0d cnt=%0d want all 0",
                     valid_out, fifo_rd_en, data_out, src_out, pop_count);
        end
        @(negedge clk);
        reset_L = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_valid got %0d outputs want 0", obs_q.size());
        end
    endtask

    initial begin
        reset_L = 1'b0;
        down_almost_full = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
`ifdef ARB_FIXED_PRIORITY_EN
        test_order("all_four", 8, '{0, 1, 0, 1, 2, 3, 2, 3});
`else
        test_order("all_four", 8, '{0, 1, 2, 3, 0, 1, 2, 3});
`endif
        test_order("fifo0_fifo3", 6, '{0, 3, 0, 3, 0, 3});
        test_backpressure();
        test_wrap();
        test_abort();
        checks++;
        if (multi_hot != 0 || underflow != 0) begin
            errors++;
            $display("FAIL rd_en_sanity multi_hot=%0d underflow=%0d want 0/0", multi_hot, underflow);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
